// File: rtl/core4_cpu_oci_dct_packer_if.sv
// rtl/core4_cpu_oci_dct_packer_if.sv - packed DCT word output stream (valid/ready)
interface core4_cpu_oci_dct_packer_if;
    logic        dct_valid;
    logic        dct_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;

    modport master (
        output dct_valid,
        output dct_buffer,
        output dct_count,
        input  dct_ready
    );

    modport slave (
        input  dct_valid,
        input  dct_buffer,
        input  dct_count,
        output dct_ready
    );
endinterface

// File: rtl/core4_cpu_oci_dct_packer.sv
// rtl/core4_cpu_oci_dct_packer.sv - packs 2-bit DCT trace frames into 30-bit words, sequences end-of-test drain
module core4_cpu_oci_dct_packer #(
    parameter int DROP_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       trc_on,
    input  logic                       trc_valid,
    input  logic [1:0]                 trc_code,
    input  logic                       flush,
    input  logic                       sim_end_req,
    core4_cpu_oci_dct_packer_if.master dct,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_count,
    output logic                       test_ending,
    output logic                       test_has_ended
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_ENDING = 2'd2;
    localparam logic [1:0] ST_ENDED  = 2'd3;

    logic [1:0]  state;
    logic [29:0] acc;
    logic [3:0]  acc_cnt;
    logic        flush_pending;

    logic        accept, can_load, flush_eff, full, load, drop, pend_nxt;
    logic [29:0] frame_word, appended, load_word, acc_nxt;
    logic [3:0]  n, load_cnt, cnt_nxt;

    always_comb begin
        accept     = trc_on & trc_valid & (trc_code != 2'b00) & (state == ST_RUN);
        can_load   = !dct.dct_valid | dct.dct_ready;
        flush_eff  = flush | flush_pending | (state == ST_DRAIN);
        full       = (acc_cnt == 4'd15);
        frame_word = {28'b0, trc_code} << {acc_cnt, 1'b0};
        appended   = accept ? (acc | frame_word) : acc;
        n          = acc_cnt + {3'b0, accept};

        load      = 1'b0;
        drop      = 1'b0;
        load_word = appended;
        load_cnt  = n;
        acc_nxt   = appended;
        cnt_nxt   = n;

        if (full) begin
            // Stalled full word: a frame arriving with the load restarts the accumulator at slot 0.
            load_word = acc;
            load_cnt  = 4'd15;
            if (can_load) begin
                load    = 1'b1;
                acc_nxt = accept ? {28'b0, trc_code} : 30'b0;
                cnt_nxt = accept ? 4'd1 : 4'd0;
            end else begin
                acc_nxt = acc;
                cnt_nxt = 4'd15;
                drop    = accept;
            end
        end else if (can_load && (n == 4'd15 || (flush_eff && n != 4'd0))) begin
            load    = 1'b1;
            acc_nxt = 30'b0;
            cnt_nxt = 4'd0;
        end

        if (load)
            pend_nxt = 1'b0;
        else if (flush && cnt_nxt != 4'd0)
            pend_nxt = 1'b1;
        else if (cnt_nxt == 4'd0)
            pend_nxt = 1'b0;
        else
            pend_nxt = flush_pending;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_RUN;
            acc            <= 30'b0;
            acc_cnt        <= 4'd0;
            flush_pending  <= 1'b0;
            dct.dct_valid  <= 1'b0;
            dct.dct_buffer <= 30'b0;
            dct.dct_count  <= 4'd0;
            overflow       <= 1'b0;
            drop_count     <= '0;
            test_ending    <= 1'b0;
            test_has_ended <= 1'b0;
        end else begin
            acc           <= acc_nxt;
            acc_cnt       <= cnt_nxt;
            flush_pending <= pend_nxt;

            if (load) begin
                dct.dct_valid  <= 1'b1;
                dct.dct_buffer <= load_word;
                dct.dct_count  <= load_cnt;
            end else if (dct.dct_ready) begin
                dct.dct_valid  <= 1'b0;
            end

            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != {DROP_W{1'b1}})
                    drop_count <= drop_count + DROP_W'(1);
            end

            test_ending <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (sim_end_req)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Drain is complete once nothing is buffered and the last word has been taken.
                    if (acc_cnt == 4'd0 && !dct.dct_valid) begin
                        state       <= ST_ENDING;
                        test_ending <= 1'b1;
                    end
                end
                ST_ENDING: begin
                    state          <= ST_ENDED;
                    test_has_ended <= 1'b1;
                end
                default: state <= ST_ENDED;
            endcase
        end
    end

endmodule

// File: tb/tb_core4_cpu_oci_dct_packer.sv
// tb/tb_core4_cpu_oci_dct_packer.sv - directed self-checking bench for the DCT packer
module tb_core4_cpu_oci_dct_packer;

    logic       clk;
    logic       reset;
    logic       trc_on;
    logic       trc_valid;
    logic [1:0] trc_code;
    logic       flush;
    logic       sim_end_req;
    logic       overflow;
    logic [7:0] drop_count;
    logic       test_ending;
    logic       test_has_ended;

    int n_checks = 0;
    int n_fail   = 0;

    core4_cpu_oci_dct_packer_if dct_if ();

    core4_cpu_oci_dct_packer #(.DROP_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .trc_on         (trc_on),
        .trc_valid      (trc_valid),
        .trc_code       (trc_code),
        .flush          (flush),
        .sim_end_req    (sim_end_req),
        .dct            (dct_if),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [1:0] code);
        trc_valid = 1'b1;
        trc_code  = code;
        tick();
        trc_valid = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [29:0] buf_exp, input logic [3:0] cnt_exp);
        check({tag, "_valid"}, dct_if.dct_valid, 1'b1);
        check({tag, "_buffer"}, dct_if.dct_buffer, buf_exp);
        check({tag, "_count"}, dct_if.dct_count, cnt_exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, dct_if.dct_valid, 1'b0);
        check({tag, "_buffer"}, dct_if.dct_buffer, 30'h0);
        check({tag, "_count"}, dct_if.dct_count, 4'h0);
        check({tag, "_overflow"}, overflow, 1'b0);
        check({tag, "_drop"}, drop_count, 8'h0);
        check({tag, "_ending"}, test_ending, 1'b0);
        check({tag, "_ended"}, test_has_ended, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; trc_on = 1'b0; trc_valid = 1'b0; trc_code = 2'b00;
        flush = 1'b0; sim_end_req = 1'b0; dct_if.dct_ready = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        reset = 1'b0;
        trc_on = 1'b1;
        dct_if.dct_ready = 1'b1;

        // Back-to-back full words, one frame per cycle.
        for (int i = 0; i < 30; i++) begin
            trc_valid = 1'b1;
            trc_code  = 2'b10;
            tick();
            if (i == 13) check("full_pre_valid", dct_if.dct_valid, 1'b0);
            if (i == 14) check_word("full1", 30'h2AAAAAAA, 4'd15);
            if (i == 15) check("full1_one_cycle", dct_if.dct_valid, 1'b0);
            if (i == 29) check_word("full2", 30'h2AAAAAAA, 4'd15);
        end
        trc_valid = 1'b0;
        tick();
        check("full2_done", dct_if.dct_valid, 1'b0);

        // Partial flush of three frames.
        frame(2'b01); frame(2'b10); frame(2'b11);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_word("flush3", 30'h39, 4'd3);
        check("flush3_acc_empty", dut.acc_cnt, 4'd0);

        // Flush in the same cycle as a frame includes it.
        frame(2'b11);
        flush = 1'b1;
        frame(2'b01);
        check_word("flush_same", 30'h7, 4'd2);
        tick();
        flush = 1'b0;
        check("flush_empty_noop", dct_if.dct_valid, 1'b0);

        // Stalled output: accumulator fills, 31st frame dropped.
        dct_if.dct_ready = 1'b0;
        for (int i = 0; i < 31; i++) begin
            frame(2'b01);
            if (i == 29) begin
                check("stall_acc_cnt", dut.acc_cnt, 4'd15);
                check("stall_no_overflow", overflow, 1'b0);
                check_word("stall_word1", 30'h15555555, 4'd15);
            end
        end
        check("drop_overflow", overflow, 1'b1);
        check("drop_count", drop_count, 8'd1);
        dct_if.dct_ready = 1'b1;
        tick();
        check_word("stall_word2", 30'h15555555, 4'd15);
        check("stall_acc_after", dut.acc_cnt, 4'd0);
        tick();
        check("stall_drained", dct_if.dct_valid, 1'b0);

        // Flush while stalled becomes pending.
        dct_if.dct_ready = 1'b0;
        for (int i = 0; i < 15; i++) frame(2'b11);
        frame(2'b10); frame(2'b01); frame(2'b11); frame(2'b10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("pend_set", dut.flush_pending, 1'b1);
        check("pend_acc_cnt", dut.acc_cnt, 4'd4);
        tick();
        check_word("pend_hold", 30'h3FFFFFFF, 4'd15);
        check("pend_still", dut.flush_pending, 1'b1);
        dct_if.dct_ready = 1'b1;
        tick();
        check_word("pend_word", 30'hB6, 4'd4);
        check("pend_cleared", dut.flush_pending, 1'b0);
        tick();
        check("pend_drained", dct_if.dct_valid, 1'b0);
        check("overflow_sticky", overflow, 1'b1);

        // End-of-test drain.
        for (int i = 0; i < 5; i++) frame(2'b01);
        sim_end_req = 1'b1;
        tick();
        sim_end_req = 1'b0;
        trc_valid = 1'b1;
        trc_code  = 2'b11;
        tick();
        check_word("drain_word", 30'h155, 4'd5);
        tick();
        check("drain_out_empty", dct_if.dct_valid, 1'b0);
        check("drain_ignores", dut.acc_cnt, 4'd0);
        check("drain_no_end_yet", test_ending, 1'b0);
        tick();
        check("ending_pulse", test_ending, 1'b1);
        check("ending_not_ended", test_has_ended, 1'b0);
        tick();
        check("ending_one_cycle", test_ending, 1'b0);
        check("ended_set", test_has_ended, 1'b1);
        tick();
        check("ended_sticky", test_has_ended, 1'b1);
        check("ended_ignores", dct_if.dct_valid, 1'b0);
        trc_valid = 1'b0;

        // Reset mid-word with a stalled output word.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dct_if.dct_ready = 1'b0;
        for (int i = 0; i < 22; i++) frame(2'b10);
        check("mid_acc_cnt", dut.acc_cnt, 4'd7);
        check("mid_valid", dct_if.dct_valid, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("mid_reset");
        check("mid_reset_acc", dut.acc_cnt, 4'd0);
        dct_if.dct_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            frame(2'b01);
            if (i == 13) check("post_reset_no_partial", dct_if.dct_valid, 1'b0);
        end
        check_word("post_reset", 30'h15555555, 4'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core4_cpu_oci_dct_packer.md
# core4_cpu_oci_dct_packer

Packs per-cycle 2-bit direct-compressed-trace (DCT) frames from the Nios II OCI trace path into 30-bit words of up to 15 frames. It presents `dct_buffer`/`dct_count` through a valid/ready output register to the OCI test bench and trace sink. It also sequences end-of-simulation draining and drives `test_ending`/`test_has_ended`.

## Interface
- `DROP_W`, default 8, width of saturating dropped-frame counter.
- `clk` input 1 — single clock, all logic rising-edge.
- `reset` input 1 — synchronous, active-high.
- `trc_on` input 1 — trace enable; frames ignored when low.
- `trc_valid` input 1 — `trc_code` carries a frame this cycle.
- `trc_code` input 2 — frame code; 2'b00 is never sent (treated as no frame).
- `flush` input 1 — request to emit the partial word.
- `sim_end_req` input 1 — start end-of-test drain (level or pulse).
- `dct_ready` input 1 — downstream accepts output word.
- `dct_valid` output 1 — output word valid.
- `dct_buffer` output 30 — packed frames; frame k in bits [2k+1:2k].
- `dct_count` output 4 — number of frames in `dct_buffer`, 1..15 when valid.
- `overflow` output 1 — sticky; a frame was dropped.
- `drop_count` output DROP_W — dropped frames, saturating.
- `test_ending` output 1 — one-cycle pulse when drain completes.
- `test_has_ended` output 1 — sticky after drain completes.

## Operation
- Accumulator: `acc[29:0]`, `acc_cnt[3:0]`. A frame is accepted when `trc_on & trc_valid & trc_code!=0` and the FSM is RUN. It is written to slot `acc_cnt`.
- `can_load = !dct_valid | dct_ready`. The output register loads only when `can_load`. `dct_valid` clears when `dct_ready & !load`.
- `acc_cnt<15`: `n = acc_cnt + accept`.
  - If `can_load & (n==15 | (flush_eff & n!=0))`: load the output with the appended word and count `n`, then clear the accumulator (unused bits zero).
  - Otherwise, hold the appended word at count `n`.
- `acc_cnt==15` (stalled full):
  - If `can_load`: load the full word. A frame accepted the same cycle goes to slot 0, giving `acc_cnt=1`.
  - If not `can_load`: an accepted frame is dropped. `overflow<=1` and `drop_count` increments, saturating at all-ones.
- `flush_pending`: set by `flush` when a partial word cannot load. Cleared on any load or when `acc_cnt==0`. `flush_eff = flush | flush_pending | (state==DRAIN)`.
- FSM:
  - RUN→DRAIN on `sim_end_req`.
  - DRAIN ignores new frames and forces flush. DRAIN→ENDING when `acc_cnt==0 & !dct_valid`.
  - ENDING lasts one cycle, with `test_ending=1`, then goes to ENDED.
  - ENDED sets `test_has_ended=1`, ignores frames, and holds until reset.
- Reset: all outputs, accumulator, `flush_pending`, `overflow`, and `drop_count` go to 0; FSM returns to RUN.

## Timing
- All outputs are registered. The frame completing a word at edge N is visible on `dct_buffer` after edge N (latency 1).
- Output handshake: a word transfers on an edge with `dct_valid & dct_ready`. `dct_buffer`/`dct_count` are stable while `dct_valid & !dct_ready`.
- Back-to-back full words are sustainable at one frame per cycle with `dct_ready=1`.
- A flush with a frame the same cycle includes that frame in the flushed word.
- A flush with `n==0` has no effect.
- Simultaneous full transfer and new frame: the frame is never lost.
- `test_ending` is high exactly one cycle. `test_has_ended` rises on the cycle after the `test_ending` pulse.
- Reset mid-word or mid-handshake discards all state. No partial word is emitted.

## Test plan
- 15 consecutive frames of 2'b10, `dct_ready=1` → next cycle `dct_valid=1` for one cycle, `dct_buffer=30'h2AAAAAAA`, `dct_count=15`.
- Frames 01,10,11 then `flush` → `dct_buffer=30'h39`, `dct_count=3`, accumulator empty after.
- `dct_ready=0`, 31 frames of 2'b01:
  - The first word holds and the accumulator stalls at 15.
  - The 31st frame sets `overflow=1`, `drop_count=1`.
  - Raising `dct_ready` delivers the two words `30'h15555555` in order.
- `flush` with 4 frames buffered while the output is stalled → `flush_pending=1`. The count-4 word is emitted on the cycle after `dct_ready` rises and the first word drains.
- 5 frames buffered, `sim_end_req` pulse, further frames driven:
  - A count-5 word is emitted and later frames are ignored.
  - `test_ending` pulses one cycle after the output drains, then `test_has_ended` stays 1.
- Reset asserted with `acc_cnt=7` and `dct_valid=1` → next cycle all outputs 0. The following 15 frames produce a clean count-15 word.
